fifo_stream_reader: RTL and testbench

Drain-side companion to the team's 64-bit x 128-entry synchronous FIFO. It issues pops to the FIFO and absorbs the FIFO's one-cycle registered read latency. It presents popped words downstream as a valid/ready stream with full throughput, lossless back-pressure and in-order delivery. It sits between the FIFO read port and any stream consumer.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_stream_reader_if.sv | 39 +++
 rtl/fifo_reader_skid_buf.sv | 79 +++++++
 rtl/fifo_stream_reader.sv | 74 +++++++
 tb/tb_fifo_stream_reader.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the 64-bit x 128-entry synchronous FIFO and its
// drain-side stream reader.
package fifo_pkg;

    localparam int ENTRY_WIDTH = 64;
    localparam int NUM_ENTRIES = 128;

    typedef logic [ENTRY_WIDTH-1:0] entry_t;

endpackage : fifo_pkg

// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the downstream stream of the reader.
//
// Handshake semantics (downstream stream): a word transfers on every rising
// clk edge where m_valid && m_ready. Once m_valid is high, m_valid and m_data
// hold steady until that transfer; m_valid never depends on m_ready.
// FIFO side: fifo_rd_en is a pop strobe, only raised while fifo_empty is low;
// the popped word appears on fifo_rdata one cycle later and is held after.
interface fifo_stream_reader_if #(
    parameter int W = fifo_pkg::ENTRY_WIDTH
);

    logic         fifo_empty;
    logic [W-1:0] fifo_rdata;
    logic         fifo_rd_en;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_ready;

    // Reader side: pops the FIFO and sources the stream.
    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        output fifo_rd_en,
        output m_valid,
        output m_data,
        input  m_ready
    );

    // Environment side: the FIFO plus the stream consumer.
    modport slave (
        output fifo_empty,
        output fifo_rdata,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        output m_ready
    );

endinterface : fifo_stream_reader_if

// File: rtl/fifo_reader_skid_buf.sv
// Small circular buffer that absorbs the FIFO read latency. Pointers wrap
// explicitly at DEPTH-1 so DEPTH need not be a power of two. The head word is
// presented combinationally; an empty buffer presents zero, so a word pushed
// into an empty buffer only becomes visible the cycle after its push.
module fifo_reader_skid_buf
    import fifo_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int W     = ENTRY_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [W-1:0]               head_data_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) begin
            tail_d = wrap_inc(tail_q);
        end
        if (pop_i) begin
            head_d = wrap_inc(head_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared by the shared reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage write at the tail; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_i && !reset) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign count_o     = count_q;
    assign head_data_o = (count_q != '0) ? mem_q[head_q] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push_i && !pop_i && (count_q == CW'(DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop_i && (count_q == '0)));

endmodule : fifo_reader_skid_buf

// File: rtl/fifo_stream_reader.sv
// Drain-side reader for the synchronous FIFO. Pops are issued on credit: a
// pop is only requested when the local buffer has room for it plus any word
// still in flight, so the one-cycle FIFO read latency never causes loss and
// fifo_rd_en never depends on m_ready.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int ENTRY_WIDTH = fifo_pkg::ENTRY_WIDTH,
    parameter int SKID_DEPTH  = 3,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    fifo_stream_reader_if.master            bus,
    output logic [$clog2(SKID_DEPTH+1)-1:0] buf_count,
    output logic [COUNT_WIDTH-1:0]          pop_count,
    output logic                            idle
);

    localparam int CW = $clog2(SKID_DEPTH + 1);

    logic                   inflight_q, inflight_d;
    logic [COUNT_WIDTH-1:0] pop_count_q, pop_count_d;
    logic [CW-1:0]          count_w;
    logic [ENTRY_WIDTH-1:0] head_w;
    logic [CW:0]            credit_used;
    logic                   rd_en;
    logic                   handshake;

    // Credit check and pop request; the in-flight word already owns a buffer slot.
    always_comb begin
        credit_used = {1'b0, count_w} + (CW+1)'(inflight_q);
        rd_en       = en && !bus.fifo_empty && (credit_used < (CW+1)'(SKID_DEPTH)) && !reset;
        handshake   = bus.m_valid && bus.m_ready;
        inflight_d  = rd_en;
        pop_count_d = handshake ? pop_count_q + 1'b1 : pop_count_q;
    end

    // In-flight flag and delivered-word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q  <= 1'b0;
            pop_count_q <= '0;
        end else begin
            inflight_q  <= inflight_d;
            pop_count_q <= pop_count_d;
        end
    end

    fifo_reader_skid_buf #(
        .DEPTH (SKID_DEPTH),
        .W     (ENTRY_WIDTH)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (bus.fifo_rdata),
        .pop_i       (handshake),
        .count_o     (count_w),
        .head_data_o (head_w)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (count_w != '0);
    assign bus.m_data     = head_w;
    assign buf_count      = count_w;
    assign pop_count      = pop_count_q;
    assign idle           = (count_w == '0) && !inflight_q;

    a_credit: assert property (@(posedge clk) disable iff (reset)
        credit_used <= (CW+1)'(SKID_DEPTH));

endmodule : fifo_stream_reader

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a FIFO model feeds the reader, and a
// reference model (queue of popped-but-undelivered words) predicts every
// output each cycle. Directed scenarios add literal expectations.
module tb_fifo_stream_reader;

  localparam int W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic en;
  logic ready;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.W(W)) bus ();
  logic [1:0]  buf_count;
  logic [31:0] pop_count;
  logic        idle;

  fifo_stream_reader #(
    .ENTRY_WIDTH (W),
    .SKID_DEPTH  (3),
    .COUNT_WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .bus       (bus),
    .buf_count (buf_count),
    .pop_count (pop_count),
    .idle      (idle)
  );

  // ---------------- FIFO model + reference model ----------------
  logic [W-1:0] src_mem [0:4095];
  int           src_wr = 0;
  int           src_rd = 0;
  logic [W-1:0] rdata_q = '0;
  logic [W-1:0] exp_q[$];
  int           delivered = 0;
  bit           prev_rd = 1'b0;

  assign bus.fifo_empty = (src_rd == src_wr);
  assign bus.fifo_rdata = rdata_q;
  assign bus.m_ready    = ready;

  // exp_q holds every word popped from the FIFO and not yet delivered,
  // oldest first; the newest one is still in flight when prev_rd is set.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      delivered = 0;
      prev_rd   = 1'b0;
      src_rd   <= src_wr;
    end else begin
      if (((exp_q.size() - int'(prev_rd)) > 0) && ready) begin
        void'(exp_q.pop_front());
        delivered = delivered + 1;
      end
      if (bus.fifo_rd_en && (src_rd < src_wr)) begin
        rdata_q <= src_mem[src_rd];
        exp_q.push_back(src_mem[src_rd]);
        src_rd  <= src_rd + 1;
      end
      prev_rd = bus.fifo_rd_en;
    end
  end

  // ---------------- scoreboard ----------------
  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic model_check();
    int           occ;
    int           eb;
    logic         erd;
    logic [W-1:0] ed;
    occ = exp_q.size();
    eb  = occ - int'(prev_rd);
    erd = !reset && en && (src_rd != src_wr) && (occ < 3);
    ed  = (eb > 0) ? exp_q[0] : '0;
    chk("rd_en",     W'(bus.fifo_rd_en), W'(erd));
    chk("m_valid",   W'(bus.m_valid),    W'(eb > 0));
    chk("buf_count", W'(buf_count),      W'(eb));
    chk("m_data",    bus.m_data,         ed);
    chk("pop_count", W'(pop_count),      W'(delivered));
    chk("idle",      W'(idle),           W'(occ == 0));
  endtask

  // ---------------- driver tasks ----------------
  logic         obs_rd, obs_valid, obs_idle;
  logic [W-1:0] obs_data;
  logic [1:0]   obs_buf;
  logic [31:0]  obs_pc;

  task automatic tick();
    @(negedge clk);
    obs_rd    = bus.fifo_rd_en;
    obs_valid = bus.m_valid;
    obs_data  = bus.m_data;
    obs_buf   = buf_count;
    obs_pc    = pop_count;
    obs_idle  = idle;
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] w);
    if (src_wr < 4096) begin
      src_mem[src_wr] = w;
      src_wr++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int           first_rd, first_valid, run, max_run, seen, n_rd, n_got;
  bit           done;
  logic [W-1:0] got [0:7];

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    ready = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset held with a non-empty FIFO
    for (int i = 0; i < 2; i++) begin
      push(64'hDEAD_0000 + 64'(i));
      tick();
      chk("t1_rd",    W'(obs_rd),    '0);
      chk("t1_valid", W'(obs_valid), '0);
      chk("t1_buf",   W'(obs_buf),   '0);
      chk("t1_pc",    W'(obs_pc),    '0);
      chk("t1_idle",  W'(obs_idle),  W'(1));
    end
    reset = 1'b0;

    // 2: single word, latency N -> N+2
    en = 1'b1; ready = 1'b1;
    push(64'hA5A5_0000_0000_00A5);
    tick();
    chk("t2_rd_n",     W'(obs_rd),    W'(1));
    chk("t2_valid_n",  W'(obs_valid), '0);
    tick();
    chk("t2_rd_n1",    W'(obs_rd),    '0);
    chk("t2_valid_n1", W'(obs_valid), '0);
    tick();
    chk("t2_valid_n2", W'(obs_valid), W'(1));
    chk("t2_data_n2",  obs_data,      64'hA5A5_0000_0000_00A5);
    tick();
    chk("t2_valid_n3", W'(obs_valid), '0);
    chk("t2_pc",       W'(obs_pc),    W'(1));
    chk("t2_idle",     W'(obs_idle),  W'(1));

    // 3: 128 preloaded words at full throughput
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 128; i++) push(64'(i));
    en = 1'b1; ready = 1'b1;
    first_rd = -1; first_valid = -1; run = 0; max_run = 0; seen = 0; n_rd = 0; done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      tick();
      if (obs_rd) begin
        n_rd++;
        if (first_rd < 0) first_rd = t;
      end
      if (obs_valid) begin
        if (first_valid < 0) first_valid = t;
        chk("t3_order", obs_data, 64'(seen));
        seen++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (obs_pc == 32'd128 && !obs_valid) done = 1'b1;
    end
    chk("t3_first_rd", 64'(first_rd), 64'd0);
    chk("t3_latency",  64'(first_valid - first_rd), 64'd2);
    chk("t3_run",      64'(max_run), 64'd128);
    chk("t3_pops",     64'(n_rd), 64'd128);
    chk("t3_pc",       W'(obs_pc), 64'd128);

    // 4: back-pressure for 10 cycles
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 40; i++) push(64'd1000 + 64'(i));
    en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_stall_data", obs_data, 64'd1003);
    end
    chk("t4_buf_full", W'(obs_buf), W'(3));
    chk("t4_rd_held",  W'(obs_rd),  '0);
    chk("t4_pc_stall", W'(obs_pc),  W'(3));
    ready = 1'b1;
    run = 0; done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      tick();
      if (obs_valid) run++;
      else done = 1'b1;
    end
    chk("t4_no_gap", 64'(run), 64'd37);
    chk("t4_pc",     W'(obs_pc), 64'd40);

    // 5: stale read data after drain, then en dropped mid-stream
    for (int i = 0; i < 20; i++) begin
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("t5_stale_buf",  W'(obs_buf),  '0);
    chk("t5_stale_idle", W'(obs_idle), W'(1));
    chk("t5_stale_pc",   W'(obs_pc),   64'd40);
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 20; i++) push(64'h5000 + 64'(i));
    en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t5_en_pc",   W'(obs_pc),   64'd4);
    chk("t5_en_idle", W'(obs_idle), W'(1));
    en = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("t5_rest_pc", W'(obs_pc), 64'd20);

    // 6: reset with buf_count=2 and a word in flight
    do_reset();
    en = 1'b0; ready = 1'b0;
    for (int i = 0; i < 10; i++) push(64'd500 + 64'(i));
    en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    chk("t6_pre_buf",  W'(obs_buf),  W'(2));
    chk("t6_pre_idle", W'(obs_idle), '0);
    reset = 1'b0;
    tick();
    chk("t6_post_valid", W'(obs_valid), '0);
    chk("t6_post_buf",   W'(obs_buf),   '0);
    chk("t6_post_pc",    W'(obs_pc),    '0);
    push(64'h11);
    push(64'h22);
    ready = 1'b1;
    n_got = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_valid && n_got < 8) begin
        got[n_got] = obs_data;
        n_got++;
      end
    end
    chk("t6_count", 64'(n_got), 64'd2);
    chk("t6_w0",    got[0],     64'h11);
    chk("t6_w1",    got[1],     64'h22);

    // randomized traffic with one reset in the middle
    for (int c = 0; c < 1500; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && src_wr < 4000) push({$urandom, $urandom});
      if (c == 700) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      tick();
    end
    en = 1'b1; ready = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 5000 && !done; t++) begin
      tick();
      if ((src_rd == src_wr) && obs_idle) done = 1'b1;
    end
    chk("rand_drained", W'(done), W'(1));

    // final report
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_fifo_stream_reader
